// File: rtl/tec8_pkg.sv
// Shared widths, 74181 function codes and register-index type for the TEC-8 datapath.
package tec8_pkg;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = DW;
  localparam int unsigned NREG = 4;

  localparam logic [3:0] ALU_ADD   = 4'b1001;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_INC   = 4'b0000;
  localparam logic [3:0] ALU_DEC   = 4'b1111;
  localparam logic [3:0] ALU_PASSB = 4'b1010;
  localparam logic [3:0] ALU_AND   = 4'b1011;
  localparam logic [3:0] ALU_XOR   = 4'b0110;
  localparam logic [3:0] ALU_PASSA = 4'b1111;

  typedef logic [1:0] reg_idx_t;

endpackage

// File: rtl/tec8_datapath_if.sv
// Controller/memory side of the datapath: per-beat control lines in, flags, IR and memory bus out.
interface tec8_datapath_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
);
  logic          t3;
  logic          drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw;
  logic          lir, ldz, ldc, cin, m, abus, sbus, mbus;
  logic [3:0]    s;
  logic          sel3, sel2, sel1, sel0;
  logic [DW-1:0] sd;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [3:0]    ir;
  logic          c, z;
  logic [AW-1:0] pc_o, ar_o;
  logic [DW-1:0] dbus_o;
  logic          bus_err;

  modport master (
    output t3, drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw,
    output lir, ldz, ldc, cin, m, abus, sbus, mbus, s,
    output sel3, sel2, sel1, sel0, sd, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, ir, c, z, pc_o, ar_o, dbus_o, bus_err
  );

  modport slave (
    input  t3, drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw,
    input  lir, ldz, ldc, cin, m, abus, sbus, mbus, s,
    input  sel3, sel2, sel1, sel0, sd, mem_rdata,
    output mem_addr, mem_wdata, mem_we, ir, c, z, pc_o, ar_o, dbus_o, bus_err
  );
endinterface

// File: rtl/tec8_alu74181.sv
// Combinational 74181-style ALU: full logic set for m=1, reduced arithmetic set for m=0.
module tec8_alu74181 #(
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [3:0]    i_s,
  input  logic          i_m,
  input  logic          i_ci,
  output logic [DW-1:0] o_f,
  output logic          o_carry
);
  import tec8_pkg::*;

  logic [DW-1:0] w_logic;
  logic [DW-1:0] w_x;
  logic [DW:0]   w_sum;

  // Active-high 74181 logic functions
  always_comb begin
    w_logic = '0;
    case (i_s)
      4'b0000:   w_logic = ~i_a;
      4'b0001:   w_logic = ~(i_a | i_b);
      4'b0010:   w_logic = ~i_a & i_b;
      4'b0011:   w_logic = '0;
      4'b0100:   w_logic = ~(i_a & i_b);
      4'b0101:   w_logic = ~i_b;
      ALU_XOR:   w_logic = i_a ^ i_b;
      4'b0111:   w_logic = i_a & ~i_b;
      4'b1000:   w_logic = ~i_a | i_b;
      4'b1001:   w_logic = ~(i_a ^ i_b);
      ALU_PASSB: w_logic = i_b;
      ALU_AND:   w_logic = i_a & i_b;
      4'b1100:   w_logic = '1;
      4'b1101:   w_logic = i_a | ~i_b;
      4'b1110:   w_logic = i_a | i_b;
      ALU_PASSA: w_logic = i_a;
    endcase
  end

  // Second addend; unlisted codes reduce to A + ci
  always_comb begin
    w_x = '0;
    case (i_s)
      ALU_ADD: w_x = i_b;
      ALU_SUB: w_x = ~i_b;
      ALU_DEC: w_x = '1;
      default: w_x = '0;
    endcase
  end

  assign w_sum   = {1'b0, i_a} + {1'b0, w_x} + (DW+1)'(i_ci);
  assign o_f     = i_m ? w_logic : w_sum[DW-1:0];
  assign o_carry = i_m ? 1'b0 : w_sum[DW];

endmodule

// File: rtl/tec8_datapath.sv
// TEC-8 datapath: register file, PC/AR/IR, C/Z flags, ALU and the shared internal data bus.
module tec8_datapath #(
  parameter int unsigned   DW     = 8,
  parameter int unsigned   AW     = 8,
  parameter logic [AW-1:0] PC_RST = 8'h00
) (
  input  logic          clk,
  input  logic          clr,
  tec8_datapath_if.slave bus
);
  import tec8_pkg::*;

  logic [DW-1:0] r_reg [NREG];
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_ar;
  logic [DW-1:0] r_ir;
  logic          r_c;
  logic          r_z;

  reg_idx_t      w_a_idx;
  reg_idx_t      w_b_idx;
  logic [DW-1:0] w_ra;
  logic [DW-1:0] w_rb;
  logic [DW-1:0] w_f;
  logic          w_carry;
  logic [DW-1:0] w_dbus;
  logic [AW-1:0] w_pc_off;

  // Register selection: switches when selctl, otherwise the IR operand fields
  assign w_a_idx = bus.selctl ? {bus.sel3, bus.sel2} : r_ir[3:2];
  assign w_b_idx = bus.selctl ? {bus.sel1, bus.sel0} : r_ir[1:0];
  assign w_ra    = r_reg[w_a_idx];
  assign w_rb    = r_reg[w_b_idx];

  // Chip Cn is active-low, hence the inversion of cin
  tec8_alu74181 #(.DW(DW)) u_alu (
    .i_a     (w_ra),
    .i_b     (w_rb),
    .i_s     (bus.s),
    .i_m     (bus.m),
    .i_ci    (~bus.cin),
    .o_f     (w_f),
    .o_carry (w_carry)
  );

  always_comb begin
    w_dbus = '0;
    if (bus.abus)      w_dbus = w_f;
    else if (bus.sbus) w_dbus = bus.sd;
    else if (bus.mbus) w_dbus = bus.mem_rdata;
  end

  assign bus.bus_err = (bus.abus & bus.sbus) | (bus.abus & bus.mbus) | (bus.sbus & bus.mbus);

  assign w_pc_off = {{(AW-4){r_ir[3]}}, r_ir[3:0]};

  // All architectural state advances only on a t3 beat
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < int'(NREG); i++) r_reg[i] <= '0;
      r_pc <= PC_RST;
      r_ar <= '0;
      r_ir <= '0;
      r_c  <= 1'b0;
      r_z  <= 1'b0;
    end else if (bus.t3) begin
      if (bus.drw) r_reg[w_a_idx] <= w_dbus;

      if (bus.lpc)        r_pc <= AW'(w_dbus);
      else if (bus.pcadd) r_pc <= r_pc + w_pc_off;
      else if (bus.pcinc) r_pc <= r_pc + AW'(1);

      if (bus.lar)        r_ar <= AW'(w_dbus);
      else if (bus.arinc) r_ar <= r_ar + AW'(1);

      if (bus.lir) r_ir <= bus.mem_rdata;
      if (bus.ldc) r_c  <= w_carry;
      if (bus.ldz) r_z  <= (w_f == '0);
    end
  end

  // Fetch addresses memory through PC, everything else through AR
  assign bus.mem_addr  = bus.lir ? r_pc : r_ar;
  assign bus.mem_wdata = w_dbus;
  assign bus.mem_we    = bus.memw & bus.t3;

  assign bus.ir      = r_ir[DW-1:DW-4];
  assign bus.c       = r_c;
  assign bus.z       = r_z;
  assign bus.pc_o    = r_pc;
  assign bus.ar_o    = r_ar;
  assign bus.dbus_o  = w_dbus;

endmodule

// File: doc/tec8_datapath.md
Name: tec8_datapath

Overview:
Executing end of the hardwired controller's control-signal interface. Holds R0-R3, PC, AR, IR, C/Z flags, a 74181-style ALU and the internal data bus. Consumes the per-beat control lines and returns ir[7:4], c and z to the controller. Drives the external single-port memory.

Parameters:
DW, 8, data/register width
AW, 8, memory address width (equals DW)
PC_RST, 8'h00, PC value after clr

Ports:
clk  in  1  system clock
clr  in  1  reset, asynchronous, active-low
t3  in  1  beat write strobe; all state updates only on rising clk with t3=1
drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw, lir, ldz, ldc, cin, m, abus, sbus, mbus  in  1 each  controller control lines
s  in  4  ALU function select
sel3, sel2, sel1, sel0  in  1 each  register selects when selctl=1
sd  in  DW  switch data
mem_rdata  in  DW  memory read data (combinational)
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_we  out  1  memory write enable
ir  out  4  IR[7:4] to controller
c, z  out  1 each  flags to controller
pc_o, ar_o, dbus_o  out  DW each  lamp/debug views
bus_err  out  1  more than one bus driver asserted

Behaviour:
- Reset (clr=0, async): R0-R3=0, AR=0, IR=0, PC=PC_RST, c=z=0. Outputs derived from these. Reset mid-beat discards any pending write.
- Register selection: selctl=1 -> dest=A={sel3,sel2}, B={sel1,sel0}. selctl=0 -> dest=A=IR[3:2], B=IR[1:0]. Ra/Rb are read combinationally.
- ALU: carry-in ci = ~cin (74181 Cn polarity). M=1 gives full 74181 logic set: 1010=B, 1111=A, 1011=A&B, 0110=A^B; the other 12 codes follow the 74181 table.
- ALU arithmetic, M=0: F = A + X + ci as a 9-bit sum; carry = bit 8. X: 0000 -> 0; 1001 -> B; 0110 -> ~B; 1111 -> 8'hFF. Other codes compute A+ci.
- Logic mode: carry=0.
- Data bus: dbus = F if abus, sd if sbus, mem_rdata if mbus, else 0. Priority abus>sbus>mbus. bus_err = 1 when two or more are asserted (combinational).
- Memory: mem_addr = PC when lir=1, else AR. mem_wdata = dbus. mem_we = memw & t3, asynchronous to clk edges (level-qualified).
- Update at rising clk with t3=1:
  - drw: R[dest] <= dbus.
  - PC priority lpc > pcadd > pcinc. lpc: PC<=dbus. pcadd: PC <= PC + sign-extended IR[3:0]. pcinc: PC <= PC+1.
  - AR priority lar > arinc. lar: AR<=dbus. arinc: AR <= AR+1.
  - lir: IR <= mem_rdata.
  - ldc: c <= ALU carry. ldz: z <= (F==0).
  - Independent targets update in the same edge. Sources are sampled pre-edge, so drw plus ldz on one beat uses the old register values.
- Arithmetic is modulo 2^DW for PC, AR and PCADD. FF+1 wraps to 00. PC=01 with offset 4'hE gives FF.
- With t3=0, no state changes; combinational outputs still track their inputs.

Decomposition:
- Package tec8_pkg: DW, ALU S-code localparams (ALU_ADD=1001, ALU_SUB=0110, ALU_INC=0000, ALU_DEC=1111, ALU_PASSB=1010, ALU_AND=1011, ALU_XOR=0110), register index type.
- One sub-module tec8_alu74181 (combinational: A, B, s, m, ci -> F, carry). The regfile, PC, AR, IR and flags live in the top.

Test Plan:
- Reset: clr low with t3 pulsing -> PC=00, AR=00, R0-R3=00, c=z=0; release -> all values held.
- Register write/read: selctl=1, sel3:2=01, sbus, drw, sd=5A, t3 beat. Then sel3:2=01, s=1111, m=1, abus -> dbus_o=5A, bus_err=0.
- ADD with flags: R0=FF, R1=01 via IR=0x01 (selctl=0), s=1001, m=0, cin=1, abus, drw, ldc, ldz -> R0=00, c=1, z=1.
- SUB/INC/DEC: R0=05, R1=07, SUB (s=0110, cin=0) -> R0=FE, c=0. INC (s=0000, cin=0) on FF -> 00, c=1. DEC (s=1111, cin=1) on 00 -> FF.
- Fetch and jump: PC=FF, lir+pcinc with mem_rdata=3E -> IR=3E, PC=00, ir=3. Then pcadd with IR[3:0]=E -> PC=FE. lpc, pcinc and pcadd together with dbus=40 -> PC=40.
- Memory: lar dbus=80 then memw with sbus sd=A5 -> mem_addr=80, mem_we high only during t3, mem_wdata=A5. arinc at AR=FF -> 00. abus+sbus together -> bus_err=1, dbus=F.
